// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the generic elastic pipeline register chain.
package pipe_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_SIDX_W = $clog2(DEF_DEPTH);

   typedef logic [DEF_SIDX_W-1:0] stage_idx_t;

   // Kill counter must stick at all-ones rather than wrap.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus payload, with kill > hold > bubble > load priority.
module pipe_stage #(
   parameter int WIDTH = 32
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             bubble,
   input  logic             hold,
   input  logic             kill,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic             valid_nxt,
   output logic [WIDTH-1:0] data
);

   logic take;

   always_comb begin
      valid_nxt = valid;
      if (kill)
         valid_nxt = 1'b0;
      else if (hold)
         valid_nxt = valid;
      else if (load)
         valid_nxt = src_valid && !bubble;
   end

   // Payload only moves on a real transfer; empty slots keep stale data.
   assign take = load && src_valid && !bubble && !hold && !kill;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= valid_nxt;
         if (take)
            data <= src_data;
      end
   end

endmodule

// File: rtl/pipe_chain.sv
// Generic elastic pipe-register chain: combinational ready path, registered valid/data,
// per-stage hold/bubble and flush, occupancy and saturating kill counters.
module pipe_chain
   import pipe_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int SIDX_W = $clog2(DEPTH),
   localparam int OCC_W  = $clog2(DEPTH + 1)
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   hold_en,
   input  logic [SIDX_W-1:0]      hold_stage,
   input  logic                   flush_en,
   input  logic [SIDX_W-1:0]      flush_stage,
   output logic [DEPTH-1:0]       stage_valid,
   output logic [DEPTH*WIDTH-1:0] stage_data,
   output logic [OCC_W-1:0]       occupancy,
   output logic [15:0]            kill_count
);

   logic [DEPTH-1:0]            held, flush_m, bubble, valid, valid_nxt, src_valid;
   logic [DEPTH:0]              rdy;
   logic [DEPTH-1:0][WIDTH-1:0] data_q, src_data;
   logic [OCC_W-1:0]            occ_nxt, occ_q;
   logic [15:0]                 kill_n, kill_q;

   // Thermometer masks; an index past the last stage naturally covers every stage.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         held[i]    = hold_en  && (i <= int'(hold_stage));
         flush_m[i] = flush_en && (i <= int'(flush_stage));
      end
   end

   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready && !held[DEPTH-1];
      for (int i = DEPTH - 1; i >= 0; i--)
         rdy[i] = !valid[i] || rdy[i+1];
   end

   assign in_ready = reset && rdy[0] && !held[0] && !flush_en;

   // A stage fed by a frozen or killed neighbour takes a bubble instead of its entry.
   always_comb begin
      src_valid[0] = in_valid && in_ready;
      src_data[0]  = in_data;
      bubble[0]    = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         src_valid[i] = valid[i-1];
         src_data[i]  = data_q[i-1];
         bubble[i]    = (held[i-1] && !held[i]) || flush_m[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clock     (clock),
         .reset     (reset),
         .load      (rdy[g]),
         .bubble    (bubble[g]),
         .hold      (held[g]),
         .kill      (flush_m[g]),
         .src_valid (src_valid[g]),
         .src_data  (src_data[g]),
         .valid     (valid[g]),
         .valid_nxt (valid_nxt[g]),
         .data      (data_q[g])
      );
   end

   always_comb begin
      occ_nxt = '0;
      kill_n  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
         kill_n  = kill_n + 16'(valid[i] && flush_m[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         occ_q  <= '0;
         kill_q <= '0;
      end else begin
         occ_q  <= occ_nxt;
         kill_q <= sat_add16(kill_q, kill_n);
      end
   end

   assign out_valid   = valid[DEPTH-1] && !held[DEPTH-1];
   assign out_data    = data_q[DEPTH-1];
   assign stage_valid = valid;
   assign stage_data  = data_q;
   assign occupancy   = occ_q;
   assign kill_count  = kill_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed scoreboard bench for pipe_chain (DEPTH=4, WIDTH=32).
module tb_pipe_chain;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0]       in_data, out_data;
   logic                   hold_en, flush_en;
   logic [1:0]             hold_stage, flush_stage;
   logic [DEPTH-1:0]       stage_valid;
   logic [DEPTH*WIDTH-1:0] stage_data;
   logic [2:0]             occupancy;
   logic [15:0]            kill_count;

   int n_chk  = 0;
   int n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clock = ~clock;

   pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .hold_en(hold_en), .hold_stage(hold_stage),
      .flush_en(flush_en), .flush_stage(flush_stage),
      .stage_valid(stage_valid), .stage_data(stage_data),
      .occupancy(occupancy), .kill_count(kill_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   function automatic logic [31:0] sdat(input int i);
      return stage_data[i*WIDTH +: WIDTH];
   endfunction

   // Monitor: every output transfer must match the oldest expected entry.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %0h, expected no output at %0t", out_data, $time);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL out_data: got %0h, expected %0h at %0t", out_data, e, $time);
            end
         end
      end
   end

   initial begin
      logic [31:0] v1 [3];
      logic [2:0]  occ1 [7];
      logic        ov1 [7];
      int          occ_max;
      v1   = '{32'h11, 32'h22, 32'h33};
      occ1 = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      ov1  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      occ_max = 0;

      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      hold_en = 1'b0; hold_stage = '0; flush_en = 1'b0; flush_stage = '0;

      mid();
      chk("rst_in_ready",    32'(in_ready), 0);
      chk("rst_out_valid",   32'(out_valid), 0);
      chk("rst_occupancy",   32'(occupancy), 0);
      chk("rst_kill_count",  32'(kill_count), 0);
      chk("rst_stage_valid", 32'(stage_valid), 0);
      step();
      reset = 1'b1;
      mid();
      chk("in_ready_after_reset", 32'(in_ready), 1);
      step();

      // Back-to-back stream: 4-cycle latency, occupancy peaks at 3.
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k < 3) begin
            in_valid = 1'b1; in_data = v1[k]; exp_q.push_back(v1[k]);
         end else
            in_valid = 1'b0;
         step();
         chk("stream_occupancy", 32'(occupancy), 32'(occ1[k]));
         chk("stream_out_valid", 32'(out_valid), 32'(ov1[k]));
         if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      end
      chk("stream_occ_peak", 32'(occ_max), 3);

      // Fill with out_ready low, then pass-through ready.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 32'hA0 + 32'(k); exp_q.push_back(in_data);
         mid();
         chk("fill_in_ready", 32'(in_ready), 1);
         step();
      end
      in_data = 32'hA4;
      mid();
      chk("full_in_ready", 32'(in_ready), 0);
      step();
      chk("full_occupancy", 32'(occupancy), 4);
      chk("full_stage_data3", sdat(3), 32'hA0);
      out_ready = 1'b1;
      mid();
      chk("passthru_in_ready", 32'(in_ready), 1);
      exp_q.push_back(32'hA4);
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("fill_drained", 32'(exp_q.size()), 0);

      // Hold stages 0-1 for two cycles on a full stream.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 32'hB0 + 32'(k); exp_q.push_back(in_data);
         step();
      end
      hold_en = 1'b1; hold_stage = 2'd1; in_data = 32'hB4;
      mid();
      chk("hold_in_ready", 32'(in_ready), 0);
      step();
      chk("hold1_stage_valid", 32'(stage_valid), 32'b1011);
      chk("hold1_stage0", sdat(0), 32'hB3);
      chk("hold1_stage1", sdat(1), 32'hB2);
      chk("hold1_stage3", sdat(3), 32'hB1);
      step();
      chk("hold2_stage_valid", 32'(stage_valid), 32'b0011);
      hold_en = 1'b0;
      exp_q.push_back(32'hB4);
      step();
      in_data = 32'hB5; exp_q.push_back(32'hB5);
      step();
      in_valid = 1'b0;
      repeat (6) step();
      chk("hold_drained", 32'(exp_q.size()), 0);
      chk("hold_occupancy", 32'(occupancy), 0);

      // Flush stages 0-2 of a full chain: only the oldest entry survives.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 32'hD - 32'(k);
         step();
      end
      exp_q.push_back(32'hD);
      chk("flush_full", 32'(stage_valid), 32'hF);
      flush_en = 1'b1; flush_stage = 2'd2; out_ready = 1'b1; in_data = 32'hEE;
      mid();
      chk("flush_in_ready", 32'(in_ready), 0);
      step();
      flush_en = 1'b0; in_valid = 1'b0;
      chk("flush_kill_count", 32'(kill_count), 3);
      chk("flush_stage_valid", 32'(stage_valid), 0);
      repeat (3) step();
      chk("flush_drained", 32'(exp_q.size()), 0);

      // Flush 0-1 together with hold 0-2.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 32'h51 + 32'(k);
         step();
      end
      in_valid = 1'b0;
      exp_q.push_back(32'h51); exp_q.push_back(32'h52);
      out_ready = 1'b1; flush_en = 1'b1; flush_stage = 2'd1; hold_en = 1'b1; hold_stage = 2'd2;
      step();
      flush_en = 1'b0; hold_en = 1'b0;
      chk("fh_stage_valid", 32'(stage_valid), 32'b0100);
      chk("fh_stage2", sdat(2), 32'h52);
      chk("fh_kill_count", 32'(kill_count), 5);
      repeat (4) step();
      chk("fh_drained", 32'(exp_q.size()), 0);

      // Kill counter saturation.
      force dut.kill_q = 16'hFFFE;
      step();
      release dut.kill_q;
      chk("sat_preset", 32'(kill_count), 32'hFFFE);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 32'h61 + 32'(k);
         step();
      end
      in_valid = 1'b0;
      chk("sat_occupancy", 32'(occupancy), 3);
      flush_en = 1'b1; flush_stage = 2'd3;
      step();
      flush_en = 1'b0;
      chk("sat_kill_count", 32'(kill_count), 32'hFFFF);
      chk("sat_occ_after", 32'(occupancy), 0);
      in_valid = 1'b1; in_data = 32'h70;
      step();
      in_valid = 1'b0; flush_en = 1'b1;
      step();
      flush_en = 1'b0;
      chk("sat_kill_stays", 32'(kill_count), 32'hFFFF);

      // Asynchronous reset mid-stream.
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 32'h81 + 32'(k); exp_q.push_back(in_data);
         step();
      end
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_stage_valid", 32'(stage_valid), 0);
      chk("arst_out_valid",   32'(out_valid), 0);
      chk("arst_occupancy",   32'(occupancy), 0);
      chk("arst_kill_count",  32'(kill_count), 0);
      chk("arst_in_ready",    32'(in_ready), 0);
      step();
      reset = 1'b1;
      repeat (2) step();
      chk("arst_release_kill", 32'(kill_count), 0);
      chk("arst_release_ready", 32'(in_ready), 1);
      chk("final_queue_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
